fb_arbiter: RTL and testbench

Shares the single-port framebuffer RAM between two requesters. The first is the VGA scanout pixel fetch, which is hard real-time. The second is the host port (SPI command decoder), which issues pixel writes and read-backs. Host writes are buffered in a small FIFO and drain only in cycles the video fetch leaves idle. The block sits inside top, between the VGA timing/pixel path, the SPI host decoder and the framebuffer RAM, and runs on the 25.175 MHz pixel clock.

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_arbiter_if.sv | 40 ++++
 rtl/fb_wr_fifo.sv | 55 +++++
 rtl/fb_arbiter.sv | 83 ++++++++
 tb/tb_fb_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer arbiter slice.
// The video fetch, the host port and the RAM all use these widths.
package fb_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 12;

   typedef logic [DATA_W-1:0] pixel_t;
   typedef logic [ADDR_W-1:0] fb_addr_t;

   typedef enum logic [1:0] {GNT_NONE, GNT_VID, GNT_RD, GNT_WR} grant_t;

   typedef struct packed {
      fb_addr_t addr;
      pixel_t   data;
   } wr_entry_t;

endpackage

// File: rtl/fb_arbiter_if.sv
// Bundle of the video fetch, host write/read and RAM ports around fb_arbiter.
// Handshakes: a transfer happens on a rising edge where valid && ready; ready never depends on valid.
interface fb_arbiter_if
   import fb_pkg::*;
#(
   parameter int WQ_DEPTH = 4
);

   logic                        vid_req;
   fb_addr_t                    vid_addr;
   logic                        vid_rvalid;
   pixel_t                      vid_rdata;
   logic                        wr_valid;
   logic                        wr_ready;
   fb_addr_t                    wr_addr;
   pixel_t                      wr_data;
   logic                        rd_valid;
   logic                        rd_ready;
   fb_addr_t                    rd_addr;
   logic                        rd_rvalid;
   pixel_t                      rd_rdata;
   fb_addr_t                    mem_addr;
   logic                        mem_we;
   pixel_t                      mem_wdata;
   pixel_t                      mem_rdata;
   logic [$clog2(WQ_DEPTH):0]   wq_level;

   modport slave (
      input  vid_req, vid_addr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
      output vid_rvalid, vid_rdata, wr_ready, rd_ready, rd_rvalid, rd_rdata,
             mem_addr, mem_we, mem_wdata, wq_level
   );

   modport master (
      output vid_req, vid_addr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
      input  vid_rvalid, vid_rdata, wr_ready, rd_ready, rd_rvalid, rd_rdata,
             mem_addr, mem_we, mem_wdata, wq_level
   );

endinterface

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO for buffered host writes.
// Push is ignored when full and pop when empty; pointers wrap modulo DEPTH.
module fb_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 27
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign dout    = store[rptr];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      if (push_ok) store[wptr] <= din;
   end

endmodule

// File: rtl/fb_arbiter.sv
// Fixed-priority arbiter sharing the single-port framebuffer RAM between
// video scanout (never stalled), host read-back and queued host writes.
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int WQ_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   fb_arbiter_if.slave  bus
);

   grant_t    grant;
   wr_entry_t head;
   logic      full;
   logic      empty;
   logic      pop;
   fb_addr_t  last_addr;
   logic      vid_rvalid_q;
   logic      rd_rvalid_q;

   fb_wr_fifo #(
      .DEPTH (WQ_DEPTH),
      .W     ($bits(wr_entry_t))
   ) u_wq (
      .clk   (clk),
      .reset (reset),
      .push  (bus.wr_valid && !full),
      .din   ({bus.wr_addr, bus.wr_data}),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (bus.wq_level)
   );

   // Reads wait for an empty queue so they always observe earlier host writes.
   always_comb begin
      grant = GNT_NONE;
      if (bus.vid_req)                 grant = GNT_VID;
      else if (bus.rd_valid && empty)  grant = GNT_RD;
      else if (!empty)                 grant = GNT_WR;
   end

   assign pop = (grant == GNT_WR);

   always_comb begin
      bus.mem_addr = last_addr;
      bus.mem_we   = 1'b0;
      case (grant)
         GNT_VID: bus.mem_addr = bus.vid_addr;
         GNT_RD:  bus.mem_addr = bus.rd_addr;
         GNT_WR: begin
            bus.mem_addr = head.addr;
            bus.mem_we   = 1'b1;
         end
         default: bus.mem_addr = last_addr;
      endcase
   end

   assign bus.mem_wdata = head.data;
   assign bus.wr_ready  = !full;
   assign bus.rd_ready  = !bus.vid_req && empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_addr    <= '0;
         vid_rvalid_q <= 1'b0;
         rd_rvalid_q  <= 1'b0;
      end else begin
         last_addr    <= bus.mem_addr;
         vid_rvalid_q <= (grant == GNT_VID);
         rd_rvalid_q  <= (grant == GNT_RD);
      end
   end

   // RAM read data already carries the one-cycle latency; just steer the valids.
   assign bus.vid_rvalid = vid_rvalid_q;
   assign bus.rd_rvalid  = rd_rvalid_q;
   assign bus.vid_rdata  = bus.mem_rdata;
   assign bus.rd_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: RAM model, scoreboard queues, vector table
// and directed multi-cycle sequences.
module tb_fb_arbiter;
   import fb_pkg::*;

   localparam int WQ_DEPTH = 4;
   localparam int LW       = $clog2(WQ_DEPTH) + 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fb_arbiter_if #(.WQ_DEPTH(WQ_DEPTH)) bus();

   fb_arbiter #(.WQ_DEPTH(WQ_DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_we     = 0;

   logic [ADDR_W+DATA_W-1:0] wr_exp_q[$];
   logic [DATA_W-1:0]        vid_exp_q[$];
   logic [DATA_W-1:0]        rd_exp_q[$];
   pixel_t                   ram[fb_addr_t];
   pixel_t                   ref_mem[fb_addr_t];

   function automatic pixel_t pat(input fb_addr_t a);
      return a[DATA_W-1:0] ^ 12'h5A5;
   endfunction

   function automatic pixel_t ram_rd(input fb_addr_t a);
      return ram.exists(a) ? ram[a] : pat(a);
   endfunction

   function automatic pixel_t ref_rd(input fb_addr_t a);
      return ref_mem.exists(a) ? ref_mem[a] : pat(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- clock/reset helpers and RAM model ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.vid_req  = 1'b0;
      bus.vid_addr = '0;
      bus.wr_valid = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.rd_valid = 1'b0;
      bus.rd_addr  = '0;
   endtask

   always @(posedge clk) begin
      bus.mem_rdata <= ram_rd(bus.mem_addr);
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (reset) begin
         if (bus.mem_we) begin
            n_we++;
            check("we_during_vid", {31'd0, bus.vid_req}, 32'd0);
            if (wr_exp_q.size() == 0) begin
               check("unexpected_mem_we", {17'd0, bus.mem_addr}, 32'hFFFF_FFFF);
            end else begin
               check("mem_write", {5'd0, bus.mem_addr, bus.mem_wdata}, {5'd0, wr_exp_q.pop_front()});
            end
         end
         if (bus.vid_rvalid) begin
            if (vid_exp_q.size() == 0) check("unexpected_vid_rvalid", {20'd0, bus.vid_rdata}, 32'hFFFF_FFFF);
            else check("vid_rdata", {20'd0, bus.vid_rdata}, {20'd0, vid_exp_q.pop_front()});
         end
         if (bus.rd_rvalid) begin
            if (rd_exp_q.size() == 0) check("unexpected_rd_rvalid", {20'd0, bus.rd_rdata}, 32'hFFFF_FFFF);
            else check("rd_rdata", {20'd0, bus.rd_rdata}, {20'd0, rd_exp_q.pop_front()});
         end
         if (bus.vid_req) begin
            check("vid_mem_addr", {17'd0, bus.mem_addr}, {17'd0, bus.vid_addr});
            vid_exp_q.push_back(ref_rd(bus.vid_addr));
         end
         if (bus.rd_valid && bus.rd_ready) begin
            check("rd_mem_addr", {17'd0, bus.mem_addr}, {17'd0, bus.rd_addr});
            rd_exp_q.push_back(ref_rd(bus.rd_addr));
         end
         if (bus.wr_valid && bus.wr_ready) begin
            wr_exp_q.push_back({bus.wr_addr, bus.wr_data});
            ref_mem[bus.wr_addr] = bus.wr_data;
         end
      end
   end

   task automatic flush_sb();
      wr_exp_q.delete();
      vid_exp_q.delete();
      rd_exp_q.delete();
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 50 && bus.wq_level != 0; i++) step();
      step();
      check(name, {{(32-LW){1'b0}}, bus.wq_level}, 32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic     vid;
      logic     rd;
      fb_addr_t va;
      fb_addr_t ra;
      logic     exp_rd_ready;
      fb_addr_t exp_addr;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int pushed;
      int we_base;
      int lvl_exp[6];

      idle_inputs();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wq_level",   {{(32-LW){1'b0}}, bus.wq_level}, 32'd0);
      check("rst_vid_rvalid", {31'd0, bus.vid_rvalid}, 32'd0);
      check("rst_rd_rvalid",  {31'd0, bus.rd_rvalid}, 32'd0);
      check("rst_wr_ready",   {31'd0, bus.wr_ready}, 32'd1);
      check("rst_mem_we",     {31'd0, bus.mem_we}, 32'd0);
      reset = 1'b1;
      step();

      // Grant priority with an empty queue; idle rows expect the held address.
      tbl[0] = '{1'b1, 1'b0, 15'h4001, 15'h0000, 1'b0, 15'h4001};
      tbl[1] = '{1'b0, 1'b0, 15'h0000, 15'h0000, 1'b1, 15'h4001};
      tbl[2] = '{1'b0, 1'b1, 15'h0000, 15'h0200, 1'b1, 15'h0200};
      tbl[3] = '{1'b1, 1'b1, 15'h4002, 15'h0201, 1'b0, 15'h4002};
      tbl[4] = '{1'b0, 1'b0, 15'h0000, 15'h0000, 1'b1, 15'h4002};
      tbl[5] = '{1'b0, 1'b1, 15'h0000, 15'h0203, 1'b1, 15'h0203};
      for (int i = 0; i < 6; i++) begin
         bus.vid_req  = tbl[i].vid;
         bus.vid_addr = tbl[i].va;
         bus.rd_valid = tbl[i].rd;
         bus.rd_addr  = tbl[i].ra;
         @(negedge clk);
         check($sformatf("tbl%0d_rd_ready", i), {31'd0, bus.rd_ready}, {31'd0, tbl[i].exp_rd_ready});
         check($sformatf("tbl%0d_mem_addr", i), {17'd0, bus.mem_addr}, {17'd0, tbl[i].exp_addr});
         check($sformatf("tbl%0d_mem_we", i), {31'd0, bus.mem_we}, 32'd0);
         step();
      end
      idle_inputs();
      step();

      // Three back-to-back writes with no video traffic.
      we_base = n_we;
      for (int i = 0; i < 3; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr  = 15'h0010 + 15'(i);
         bus.wr_data  = (i == 0) ? 12'hF00 : (i == 1) ? 12'h0F0 : 12'h00F;
         if (i > 0) begin
            @(negedge clk);
            check("seq1_we_follows_push", {31'd0, bus.mem_we}, 32'd1);
         end
         step();
      end
      idle_inputs();
      wait_drain("seq1_drain");
      check("seq1_we_count", n_we - we_base, 32'd3);
      check("seq1_ram10", {20'd0, ram_rd(15'h0010)}, 32'hF00);
      check("seq1_ram11", {20'd0, ram_rd(15'h0011)}, 32'h0F0);
      check("seq1_ram12", {20'd0, ram_rd(15'h0012)}, 32'h00F);

      // Video holds the RAM for 20 cycles while the host offers six writes.
      we_base = n_we;
      pushed = 0;
      for (int c = 0; c < 20; c++) begin
         bus.vid_req  = 1'b1;
         bus.vid_addr = 15'h4010 + 15'(c);
         bus.wr_valid = (pushed < 6);
         bus.wr_addr  = 15'h0300 + 15'(pushed);
         bus.wr_data  = 12'h100 + 12'(pushed);
         @(negedge clk);
         if (bus.wr_valid && bus.wr_ready) pushed++;
         step();
      end
      check("seq2_pushed_under_vid", pushed, 32'd4);
      check("seq2_level_full", {{(32-LW){1'b0}}, bus.wq_level}, 32'd4);
      check("seq2_no_we_under_vid", n_we - we_base, 32'd0);
      bus.vid_req  = 1'b0;
      bus.wr_addr  = 15'h0300 + 15'(pushed);
      bus.wr_data  = 12'h100 + 12'(pushed);
      @(negedge clk);
      check("seq2_full_pop_no_bypass", {31'd0, bus.wr_ready}, 32'd0);
      check("seq2_full_pop_we", {31'd0, bus.mem_we}, 32'd1);
      for (int c = 0; c < 20 && pushed < 6; c++) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr  = 15'h0300 + 15'(pushed);
         bus.wr_data  = 12'h100 + 12'(pushed);
         @(negedge clk);
         if (bus.wr_ready) pushed++;
         step();
      end
      idle_inputs();
      check("seq2_pushed_total", pushed, 32'd6);
      wait_drain("seq2_drain");
      check("seq2_we_count", n_we - we_base, 32'd6);

      // Read-after-write: the read waits for the queued write to land.
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 15'h0100;
      bus.wr_data  = 12'hABC;
      step();
      bus.wr_valid = 1'b0;
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 15'h0100;
      @(negedge clk);
      check("seq3_rd_blocked", {31'd0, bus.rd_ready}, 32'd0);
      for (int c = 0; c < 20 && !bus.rd_ready; c++) begin
         step();
         @(negedge clk);
      end
      check("seq3_rd_ready", {31'd0, bus.rd_ready}, 32'd1);
      step();
      bus.rd_valid = 1'b0;
      @(negedge clk);
      check("seq3_rd_rvalid", {31'd0, bus.rd_rvalid}, 32'd1);
      check("seq3_rd_rdata", {20'd0, bus.rd_rdata}, 32'hABC);
      step();

      // Video every other cycle against continuous host writes.
      we_base = n_we;
      pushed = 0;
      for (int c = 0; c < 16; c++) begin
         bus.vid_req  = (c % 2 == 0);
         bus.vid_addr = 15'h4100 + 15'(c);
         bus.wr_valid = 1'b1;
         bus.wr_addr  = 15'h0400 + 15'(pushed);
         bus.wr_data  = 12'h200 + 12'($urandom_range(0, 255));
         @(negedge clk);
         if (bus.wr_ready) pushed++;
         step();
      end
      idle_inputs();
      wait_drain("seq4_drain");
      check("seq4_we_count", n_we - we_base, pushed);

      // Full queue, then push and pop together: level must stay put.
      pushed = 0;
      for (int c = 0; c < 4; c++) begin
         bus.vid_req  = 1'b1;
         bus.vid_addr = 15'h4200 + 15'(c);
         bus.wr_valid = 1'b1;
         bus.wr_addr  = 15'h0500 + 15'(pushed);
         bus.wr_data  = 12'h300 + 12'(pushed);
         @(negedge clk);
         if (bus.wr_ready) pushed++;
         step();
      end
      bus.vid_req = 1'b0;
      lvl_exp = '{4, 3, 3, 3, 3, 3};
      for (int c = 0; c < 6; c++) begin
         bus.wr_addr = 15'h0500 + 15'(pushed);
         bus.wr_data = 12'h300 + 12'(pushed);
         @(negedge clk);
         check($sformatf("seq5_level%0d", c), {{(32-LW){1'b0}}, bus.wq_level}, lvl_exp[c]);
         if (bus.wr_ready) pushed++;
         step();
      end
      idle_inputs();
      wait_drain("seq5_drain");

      // Reset with three queued writes and a video read in flight.
      for (int c = 0; c < 3; c++) begin
         bus.vid_req  = 1'b1;
         bus.vid_addr = 15'h4300 + 15'(c);
         bus.wr_valid = 1'b1;
         bus.wr_addr  = 15'h0600 + 15'(c);
         bus.wr_data  = 12'h400 + 12'(c);
         step();
      end
      idle_inputs();
      check("seq6_pre_level", {{(32-LW){1'b0}}, bus.wq_level}, 32'd3);
      reset = 1'b0;
      #1;
      flush_sb();
      check("seq6_rst_level", {{(32-LW){1'b0}}, bus.wq_level}, 32'd0);
      check("seq6_rst_vid_rvalid", {31'd0, bus.vid_rvalid}, 32'd0);
      check("seq6_rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
      check("seq6_rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      step();
      reset = 1'b1;
      we_base = n_we;
      repeat (8) step();
      check("seq6_no_we_after_release", n_we - we_base, 32'd0);

      // Reset while a host read response is pending.
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 15'h0207;
      step();
      idle_inputs();
      check("seq6_rd_pending", {31'd0, bus.rd_rvalid}, 32'd1);
      reset = 1'b0;
      #1;
      flush_sb();
      check("seq6_rst_rd_rvalid", {31'd0, bus.rd_rvalid}, 32'd0);
      step();
      reset = 1'b1;
      repeat (4) step();

      check("end_wr_q_empty",  wr_exp_q.size(), 32'd0);
      check("end_vid_q_empty", vid_exp_q.size(), 32'd0);
      check("end_rd_q_empty",  rd_exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
